wb_sram_slave_ctrl: RTL and testbench

Parametrised Wishbone classic slave that bridges a bus master onto the single-port SRAM request/finish handshake. It replaces the fixed 32-bit bridge and adds width/depth parameters, byte lanes, address-window decode with error response, master abort, and an optional watchdog. It sits between the Wishbone interconnect and the SRAM controller.

---
 rtl/wb_sram_slave_ctrl.sv | 157 +++++++++++++++
 tb/tb_wb_sram_slave_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_slave_ctrl.sv
// Wishbone classic slave bridging one bus transfer onto the SRAM access/finish handshake.
// Define WB_SLV_TIMEOUT_EN to add a watchdog that error-terminates an SRAM access after TIMEOUT_CYC cycles.
module wb_sram_slave_ctrl #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                SRAM_AW     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic [ADDR_W-1:0]   ADR_O,
    input  logic [DATA_W-1:0]   DAT_O,
    input  logic [DATA_W/8-1:0] SEL_O,
    input  logic                WE_O,
    input  logic                STB_O,
    input  logic                CYC_O,
    output logic [DATA_W-1:0]   DAT_I,
    output logic                ACK_I,
    output logic                ERR_I,
    output logic [SRAM_AW-1:0]  s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_sel,
    output logic                s_we,
    output logic                s_access,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                sram_wr_finish
);

    localparam int SW      = DATA_W / 8;
    localparam int AL      = $clog2(SW);
    localparam int WIN_LSB = SRAM_AW + AL;
    localparam logic [ADDR_W-1:0] WIN_MASK = {ADDR_W{1'b1}} << WIN_LSB;

    if ((DATA_W % 8) != 0 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("wb_sram_slave_ctrl: DATA_W must be a multiple of 8 and TIMEOUT_CYC at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_dat;
    logic                r_ack;
    logic                r_err;
    logic [SRAM_AW-1:0]  r_saddr;
    logic [DATA_W-1:0]   r_swdata;
    logic [SW-1:0]       r_ssel;
    logic                r_swe;
    logic                r_sacc;

    logic w_req;
    logic w_hit;
    logic w_expire;

    assign w_req = CYC_O & STB_O;
    assign w_hit = ((ADR_O & WIN_MASK) == BASE_ADDR);

`ifdef WB_SLV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_wdog;

    // Expiry is seen on the TIMEOUT_CYC-th ACCESS cycle that lacks a finish.
    assign w_expire = (r_wdog == TW'(TIMEOUT_CYC - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state  <= ST_IDLE;
            r_dat    <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_saddr  <= '0;
            r_swdata <= '0;
            r_ssel   <= '0;
            r_swe    <= 1'b0;
            r_sacc   <= 1'b0;
`ifdef WB_SLV_TIMEOUT_EN
            r_wdog   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    if (w_req) begin
                        if (w_hit) begin
                            r_saddr <= ADR_O[WIN_LSB-1:AL];
                            r_swe   <= WE_O;
                            r_ssel  <= SEL_O;
                            if (WE_O) begin
                                r_swdata <= DAT_O;
                            end
                            r_sacc  <= 1'b1;
`ifdef WB_SLV_TIMEOUT_EN
                            r_wdog  <= '0;
`endif
                            r_state <= ST_ACCESS;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end
                    end
                end
                // Abort outranks a same-cycle finish, which outranks watchdog expiry.
                ST_ACCESS: begin
                    if (!CYC_O) begin
                        r_sacc  <= 1'b0;
                        r_swe   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (sram_wr_finish) begin
                        r_sacc  <= 1'b0;
                        r_swe   <= 1'b0;
                        r_ack   <= 1'b1;
                        if (!r_swe) begin
                            r_dat <= s_rdata;
                        end
                        r_state <= ST_RESP;
                    end else if (w_expire) begin
                        r_sacc  <= 1'b0;
                        r_swe   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
`ifdef WB_SLV_TIMEOUT_EN
                        r_wdog  <= r_wdog + 1'b1;
`endif
                    end
                end
                // STB_O is deliberately ignored here so the terminated request is not replayed.
                ST_RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign DAT_I    = r_dat;
    assign ACK_I    = r_ack;
    assign ERR_I    = r_err;
    assign s_addr   = r_saddr;
    assign s_wdata  = r_swdata;
    assign s_sel    = r_ssel;
    assign s_we     = r_swe;
    assign s_access = r_sacc;

endmodule

// File: tb/tb_wb_sram_slave_ctrl.sv
// Scoreboard bench for wb_sram_slave_ctrl: a behavioural memory model predicts terminations and SRAM requests,
// while an SRAM responder and a bus monitor check what the DUT actually presents.
module tb_wb_sram_slave_ctrl;

    localparam int                DATA_W  = 32;
    localparam int                ADDR_W  = 32;
    localparam int                SRAM_AW = 4;
    localparam logic [31:0]       BASE    = 32'h0001_0000;
    localparam int                TMO     = 8;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] datO;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [31:0] datI;
    logic        ack;
    logic        err;
    logic [3:0]  sAddr;
    logic [31:0] sWdata;
    logic [3:0]  sSel;
    logic        sWe;
    logic        sAccess;
    logic [31:0] sRdata;
    logic        finish;

    wb_sram_slave_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW),
        .BASE_ADDR(BASE), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK_I(clk), .RST_I(rst), .ADR_O(adr), .DAT_O(datO), .SEL_O(sel),
        .WE_O(we), .STB_O(stb), .CYC_O(cyc), .DAT_I(datI), .ACK_I(ack), .ERR_I(err),
        .s_addr(sAddr), .s_wdata(sWdata), .s_sel(sSel), .s_we(sWe), .s_access(sAccess),
        .s_rdata(sRdata), .sram_wr_finish(finish)
    );

    typedef struct {
        bit          isErr;
        logic [31:0] expDat;
    } term_t;

    typedef struct {
        logic [3:0]  addr;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } acc_t;

    term_t       termQ[$];
    acc_t        accQ[$];
    logic [31:0] refMem [16];
    logic [31:0] sramMem [16];
    logic [31:0] lastRead;
    int          compared = 0;
    int          mismatched = 0;
    int          cycle = 0;
    int          finishCycle = 0;
    int          nextDelay = 0;
    bit          sramBusy = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: event did not occur within its bound", name);
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wr, input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wr[8*b +: 8];
        end
        return res;
    endfunction

    // SRAM side: validates each new request against the model's prediction, then finishes after nextDelay cycles.
    initial begin
        acc_t        a;
        logic [3:0]  capAddr;
        logic [3:0]  capSel;
        logic [31:0] capData;
        bit          capWe;
        int          d;
        finish = 1'b0;
        sRdata = $urandom;
        forever begin
            @(negedge clk);
            if (rst || !sAccess) continue;
            capAddr = sAddr;
            capSel  = sSel;
            capData = sWdata;
            capWe   = sWe;
            if (accQ.size() == 0) begin
                reportFail("unexpected_sram_access");
            end else begin
                a = accQ.pop_front();
                checkOutput("s_addr", {28'd0, capAddr}, {28'd0, a.addr});
                checkOutput("s_we", {31'd0, capWe}, {31'd0, a.we});
                checkOutput("s_sel", {28'd0, capSel}, {28'd0, a.sel});
                if (a.we) checkOutput("s_wdata", capData, a.wdata);
            end
            sramBusy = 1'b1;
            d = nextDelay;
            repeat (d) @(negedge clk);
            if (capWe) sramMem[capAddr] = mergeBytes(sramMem[capAddr], capData, capSel);
            sRdata      = sramMem[capAddr];
            finish      = 1'b1;
            finishCycle = cycle;
            @(negedge clk);
            finish   = 1'b0;
            sRdata   = $urandom;
            sramBusy = 1'b0;
        end
    end

    // Bus monitor: every ACK/ERR pops the oldest predicted termination.
    initial begin
        term_t e;
        bit    prevTerm = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevTerm = 1'b0;
                continue;
            end
            if (ack || err) begin
                checkOutput("ack_err_exclusive", {31'd0, ack & err}, 32'd0);
                checkOutput("term_pulse_width", {31'd0, prevTerm}, 32'd0);
                if (termQ.size() == 0) begin
                    checkOutput("unexpected_termination", {30'd0, ack, err}, 32'd0);
                end else begin
                    e = termQ.pop_front();
                    checkOutput("term_is_err", {31'd0, err}, {31'd0, e.isErr});
                    checkOutput("dat_i", datI, e.expDat);
                    if (ack && !e.isErr) checkOutput("ack_latency", cycle, finishCycle + 1);
                end
            end
            prevTerm = ack | err;
        end
    end

    task automatic waitTermination();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ack || err) seen = 1'b1;
        end
        if (!seen) begin
            reportFail("no_termination");
            cyc = 1'b0;
            stb = 1'b0;
            termQ.delete();
            accQ.delete();
        end
    endtask

    task automatic waitSramIdle();
        for (int i = 0; i < 60 && sramBusy; i++) @(negedge clk);
        if (sramBusy) reportFail("sram_idle");
    endtask

    task automatic predict(input logic [31:0] addr, input bit wr, input logic [3:0] be, input logic [31:0] data,
                           input bit expectTerm);
        bit         hit;
        logic [3:0] idx;
        acc_t       a;
        term_t      t;
        hit = ((addr >> 6) == (BASE >> 6));
        idx = addr[5:2];
        if (hit) begin
            a.addr = idx; a.we = wr; a.sel = be; a.wdata = data;
            accQ.push_back(a);
            if (expectTerm) begin
                if (wr) refMem[idx] = mergeBytes(refMem[idx], data, be);
                else    lastRead = refMem[idx];
            end
        end
        if (expectTerm) begin
            t.isErr  = !hit;
            t.expDat = lastRead;
            termQ.push_back(t);
        end
    endtask

    task automatic driveBus(input logic [31:0] addr, input bit wr, input logic [3:0] be, input logic [31:0] data);
        adr = addr; we = wr; sel = be; datO = data; cyc = 1'b1; stb = 1'b1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input bit wr, input logic [3:0] be,
                                 input logic [31:0] data, input int delay);
        int idle;
        predict(addr, wr, be, data, 1'b1);
        nextDelay = delay;
        driveBus(addr, wr, be, data);
        waitTermination();
        idle = $urandom_range(0, 2);
        if (idle > 0) begin
            stb = 1'b0;
            if ($urandom_range(0, 1) == 1) cyc = 1'b0;
            repeat (idle) @(negedge clk);
        end
    endtask

    task automatic applyAbort(input logic [3:0] idx);
        predict(BASE + {26'd0, idx, 2'b00}, 1'b0, 4'hF, 32'd0, 1'b0);
        nextDelay = 6;
        driveBus(BASE + {26'd0, idx, 2'b00}, 1'b0, 4'hF, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("abort_access_up", {31'd0, sAccess}, 32'd1);
        cyc = 1'b0;
        stb = 1'b0;
        @(negedge clk);
        checkOutput("abort_access_drop", {31'd0, sAccess}, 32'd0);
        waitSramIdle();
        repeat (2) @(negedge clk);
        checkOutput("abort_access_idle", {31'd0, sAccess}, 32'd0);
    endtask

    task automatic applyStall(input logic [3:0] idx);
        nextDelay = 20;
`ifdef WB_SLV_TIMEOUT_EN
        predict(BASE + {26'd0, idx, 2'b00}, 1'b0, 4'hF, 32'd0, 1'b0);
        begin
            term_t t;
            t.isErr  = 1'b1;
            t.expDat = lastRead;
            termQ.push_back(t);
        end
        driveBus(BASE + {26'd0, idx, 2'b00}, 1'b0, 4'hF, 32'd0);
        waitTermination();
        stb = 1'b0;
        cyc = 1'b0;
`else
        predict(BASE + {26'd0, idx, 2'b00}, 1'b0, 4'hF, 32'd0, 1'b0);
        driveBus(BASE + {26'd0, idx, 2'b00}, 1'b0, 4'hF, 32'd0);
        repeat (TMO + 4) @(negedge clk);
        checkOutput("stall_access_held", {31'd0, sAccess}, 32'd1);
        cyc = 1'b0;
        stb = 1'b0;
        @(negedge clk);
`endif
        waitSramIdle();
        @(negedge clk);
    endtask

    task automatic applyResetMidAccess(input logic [3:0] idx);
        predict(BASE + {26'd0, idx, 2'b00}, 1'b0, 4'hF, 32'd0, 1'b0);
        nextDelay = 10;
        driveBus(BASE + {26'd0, idx, 2'b00}, 1'b0, 4'hF, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_s_access", {31'd0, sAccess}, 32'd0);
        checkOutput("rst_ack", {31'd0, ack}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_dat_i", datI, 32'd0);
        cyc = 1'b0;
        stb = 1'b0;
        lastRead = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        waitSramIdle();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            refMem[i]  = 32'd0;
            sramMem[i] = 32'd0;
        end
        lastRead = 32'd0;
        rst = 1'b1;
        adr = '0; datO = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ack", {31'd0, ack}, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        checkOutput("reset_s_access", {31'd0, sAccess}, 32'd0);
        checkOutput("reset_dat_i", datI, 32'd0);
        checkOutput("reset_s_addr", {28'd0, sAddr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed transfers");
        applyStimulus(BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 2);
        applyStimulus(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 2);
        applyStimulus(BASE + 32'h10, 1'b1, 4'h2, 32'h0000_AB00, 1);
        applyStimulus(BASE + 32'h10, 1'b0, 4'h1, 32'h0, 0);
        applyStimulus(32'h0002_0000, 1'b0, 4'hF, 32'h0, 0);
        applyStimulus(BASE + 32'h3C, 1'b1, 4'h0, 32'h1234_5678, 1);
        applyStimulus(BASE + 32'h3C, 1'b0, 4'hF, 32'h0, 3);

        $display("[TB] abort and stall");
        applyAbort(4'h4);
        applyStimulus(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 1);
        applyStall(4'h4);
        applyStimulus(BASE + 32'h04, 1'b1, 4'hF, 32'hCAFE_F00D, 0);

        $display("[TB] random transfers");
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) a = $urandom;
            else                           a = BASE + $urandom_range(0, 63);
            applyStimulus(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("[TB] reset during access");
        applyStimulus(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 1);
        applyResetMidAccess(4'h4);
        applyStimulus(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 2);

        cyc = 1'b0;
        stb = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("term_queue_drained", termQ.size(), 32'd0);
        checkOutput("access_queue_drained", accQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
